// File: rtl/psum_collector.sv
// Re-aligns skewed per-column partial sums from a systolic MAC row into whole rows.
// One circular FIFO per column; a row is presented (FWFT) only when every column holds data.

module psum_col_fifo #(
  parameter int BW    = 16,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [BW-1:0] din_i,
  input  logic          pop_i,
  output logic [BW-1:0] dout_o,
  output logic          nempty_o,
  output logic          full_o,
  output logic          drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_ok;

  assign full_o   = (cnt_q == CNT_FULL);
  assign nempty_o = (cnt_q != '0);
  // Full check uses the pre-edge count, so a same-edge pop cannot rescue a write.
  assign wr_ok    = wr_i & ~full_o;
  assign drop_o   = wr_i & full_o;
  assign dout_o   = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_i) rptr_d = rptr_q + PTR_ONE;
    if (wr_ok && !pop_i)      cnt_d = cnt_q + CNT_ONE;
    else if (!wr_ok && pop_i) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= din_i;
  end
endmodule

module psum_collector #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         valid,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_overflow
);
  logic [col-1:0][psum_bw-1:0] head;
  logic [col-1:0]              nempty, full, drop;
  logic                        pop;
  logic                        ovf_q, ovf_d;

  assign o_valid    = &nempty;
  assign o_full     = |full;
  assign o_overflow = ovf_q;
  // Columns only ever pop as a unit, gated by the whole-row valid.
  assign pop        = rd & o_valid;
  assign ovf_d      = ovf_q | (|drop);

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_col_fifo #(.BW(psum_bw), .DEPTH(depth)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (valid[c]),
      .din_i    (in[c*psum_bw +: psum_bw]),
      .pop_i    (pop),
      .dout_o   (head[c]),
      .nempty_o (nempty[c]),
      .full_o   (full[c]),
      .drop_o   (drop[c])
    );
    assign out[c*psum_bw +: psum_bw] = o_valid ? head[c] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
endmodule
